// File: rtl/ff_array_feeder.sv
// rtl/ff_array_feeder.sv - operand injector for the GF(2^M) systolic multiplier array
// Buffers (a,b,g) requests in a 2-entry FIFO and serialises each into one LOAD/RUN/GAP frame.
module ff_array_feeder #(
  parameter int M            = 16,
  parameter int GAP          = 1,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [M-1:0] req_a,
  input  logic [M-1:0] req_b,
  input  logic [M-1:0] req_g,
  input  logic         done_i,
  output logic [M-1:0] ao,
  output logic [M-1:0] go,
  output logic [M-1:0] bo,
  output logic         ctro,
  output logic         po,
  output logic [M-2:0] poh,
  output logic [M-2:0] pov,
  output logic         busy,
  output logic [3:0]   inflight
);

  localparam int            KW       = $clog2(M + 1);
  localparam logic [KW-1:0] K_LAST   = KW'(M);
  localparam logic [KW-1:0] K_ONE    = KW'(1);
  localparam logic [1:0]    GAP_LAST = 2'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [3:0]    INFL_MAX = 4'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_GAP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0][M-1:0]   r_fa;
  logic [1:0][M-1:0]   r_fb;
  logic [1:0][M-1:0]   r_fg;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;
  logic                r_rdy_en;
  logic [M-1:0]        r_op_a;
  logic [M-1:0]        r_op_b;
  logic [M-1:0]        r_op_g;
  logic [KW-1:0]       r_k;
  logic [KW-1:0]       w_k_nxt;
  logic [1:0]          r_gcnt;
  logic [1:0]          w_gcnt_nxt;
  logic [3:0]          r_inflight;
  logic [M-1:0]        r_ao;
  logic [M-1:0]        r_go;
  logic [M-1:0]        r_bo;
  logic                r_ctro;
  logic                r_po;
  logic [M-1:0]        w_ao_nxt;
  logic [M-1:0]        w_go_nxt;
  logic [M-1:0]        w_bo_nxt;
  logic                w_ctro_nxt;
  logic                w_po_nxt;
  logic [M-1:0]        w_shift;
  logic                w_push;
  logic                w_pop;
  logic                w_launch;
  logic                w_dec;

  assign req_ready = r_rdy_en && (r_count != 2'd2);
  assign w_push    = req_valid && req_ready;
  assign w_launch  = (r_count != 2'd0) && (r_inflight < INFL_MAX);
  assign w_pop     = (w_state_nxt == S_LOAD);
  assign w_dec     = done_i && (r_inflight != 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_gcnt_nxt  = r_gcnt;
    case (r_state)
      S_IDLE: if (w_launch) w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_state_nxt = S_RUN;
        w_k_nxt     = K_ONE;
      end
      S_RUN: begin
        if (r_k == K_LAST) begin
          if (GAP > 0) begin
            w_state_nxt = S_GAP;
            w_gcnt_nxt  = 2'd0;
          end else begin
            w_state_nxt = w_launch ? S_LOAD : S_IDLE;
          end
        end else begin
          w_k_nxt = r_k + K_ONE;
        end
      end
      S_GAP: begin
        if (r_gcnt == GAP_LAST) w_state_nxt = w_launch ? S_LOAD : S_IDLE;
        else                    w_gcnt_nxt  = r_gcnt + 2'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stream outputs are computed from the next state so they appear registered in the same cycle as that state.
  always_comb begin
    w_shift    = r_op_a << (w_k_nxt - K_ONE);
    w_ao_nxt   = '0;
    w_go_nxt   = '0;
    w_bo_nxt   = '0;
    w_ctro_nxt = 1'b0;
    w_po_nxt   = 1'b0;
    case (w_state_nxt)
      S_LOAD: begin
        w_ao_nxt = r_fa[r_rd_ptr];
        w_go_nxt = r_fg[r_rd_ptr];
        w_bo_nxt = r_fb[r_rd_ptr];
      end
      S_RUN: begin
        w_ao_nxt   = r_op_a;
        w_go_nxt   = r_op_g;
        w_bo_nxt   = r_op_b;
        w_ctro_nxt = 1'b1;
        w_po_nxt   = w_shift[M-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fa       <= '0;
      r_fb       <= '0;
      r_fg       <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_rdy_en   <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_g     <= '0;
      r_k        <= '0;
      r_gcnt     <= 2'd0;
      r_inflight <= 4'd0;
      r_ao       <= '0;
      r_go       <= '0;
      r_bo       <= '0;
      r_ctro     <= 1'b0;
      r_po       <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_k      <= w_k_nxt;
      r_gcnt   <= w_gcnt_nxt;
      r_ao     <= w_ao_nxt;
      r_go     <= w_go_nxt;
      r_bo     <= w_bo_nxt;
      r_ctro   <= w_ctro_nxt;
      r_po     <= w_po_nxt;
      if (w_push) begin
        r_fa[r_wr_ptr] <= req_a;
        r_fb[r_wr_ptr] <= req_b;
        r_fg[r_wr_ptr] <= req_g;
        r_wr_ptr       <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_op_a   <= r_fa[r_rd_ptr];
        r_op_b   <= r_fb[r_rd_ptr];
        r_op_g   <= r_fg[r_rd_ptr];
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: ;
      endcase
      case ({w_pop, w_dec})
        2'b10:   r_inflight <= r_inflight + 4'd1;
        2'b01:   r_inflight <= r_inflight - 4'd1;
        default: ;
      endcase
    end
  end

  assign ao       = r_ao;
  assign go       = r_go;
  assign bo       = r_bo;
  assign ctro     = r_ctro;
  assign po       = r_po;
  assign poh      = '0;
  assign pov      = '0;
  assign busy     = (r_state != S_IDLE) || (r_count != 2'd0);
  assign inflight = r_inflight;

endmodule

// File: tb/tb_ff_array_feeder.sv
// tb/tb_ff_array_feeder.sv - self-checking bench for ff_array_feeder
module tb_ff_array_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, d0, r0, ctro0, po0, busy0;
  logic [15:0] a0, b0, g0, ao0, go0, bo0;
  logic [14:0] poh0, pov0;
  logic [3:0]  infl0;
  logic        v1, d1, r1, ctro1, po1, busy1;
  logic [15:0] a1, b1, g1, ao1, go1, bo1;
  logic [14:0] poh1, pov1;
  logic [3:0]  infl1;

  ff_array_feeder #(.M(16), .GAP(1), .MAX_INFLIGHT(4)) u0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(r0), .req_a(a0), .req_b(b0), .req_g(g0),
    .done_i(d0), .ao(ao0), .go(go0), .bo(bo0), .ctro(ctro0), .po(po0), .poh(poh0), .pov(pov0),
    .busy(busy0), .inflight(infl0));

  ff_array_feeder #(.M(16), .GAP(0), .MAX_INFLIGHT(2)) u1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(r1), .req_a(a1), .req_b(b1), .req_g(g1),
    .done_i(d1), .ao(ao1), .go(go1), .bo(bo1), .ctro(ctro1), .po(po1), .poh(poh1), .pov(pov1),
    .busy(busy1), .inflight(infl1));

  typedef struct {
    logic        vld;
    logic        done;
    logic        x_rdy;
    logic        x_ctro;
    logic        x_po;
    logic [15:0] x_ao;
    logic [15:0] x_bo;
    logic [15:0] x_go;
    logic [3:0]  x_infl;
    logic        x_busy;
  } vec_t;

  localparam logic [15:0] TA = 16'h8001;
  localparam logic [15:0] TB = 16'h0003;
  localparam logic [15:0] TG = 16'h100B;

  int   checks = 0;
  int   errors = 0;
  vec_t tv[$];
  logic lc [100];
  logic [15:0] lb [100];
  int   st [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic vld, logic done, logic rdy, logic ctro, logic po,
                              logic [15:0] ao, logic [15:0] bo, logic [15:0] go,
                              logic [3:0] infl, logic busy);
    vec_t v;
    v.vld = vld; v.done = done; v.x_rdy = rdy; v.x_ctro = ctro; v.x_po = po;
    v.x_ao = ao; v.x_bo = bo; v.x_go = go; v.x_infl = infl; v.x_busy = busy;
    return v;
  endfunction

  // Holds valid until a transfer happens; returns the number of stalled cycles.
  task automatic send(input int sel, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] g, output int waits);
    logic rdy;
    bit   ok;
    waits = 0;
    ok    = 1'b0;
    if (sel == 0) begin v0 = 1'b1; a0 = a; b0 = b; g0 = g; end
    else          begin v1 = 1'b1; a1 = a; b1 = b; g1 = g; end
    for (int i = 0; i < 100; i++) begin
      rdy = (sel == 0) ? r0 : r1;
      @(negedge clk);
      if (rdy) begin ok = 1'b1; break; end
      waits++;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    if (sel == 0) v0 = 1'b0;
    else          v1 = 1'b0;
  endtask

  task automatic log_cycles(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lc[i] = (sel == 0) ? ctro0 : ctro1;
      lb[i] = (sel == 0) ? bo0 : bo1;
    end
  endtask

  function automatic logic frame_ok(int base, logic [15:0] b, bit with_gap);
    logic ok;
    ok = (lc[base] == 1'b0) && (lb[base] == b);
    for (int k = 1; k <= 16; k++) ok = ok && (lc[base+k] == 1'b1) && (lb[base+k] == b);
    if (with_gap) ok = ok && (lc[base+17] == 1'b0) && (lb[base+17] == 16'h0);
    return ok;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    int l0;
    rst = 1'b0;
    v0 = 0; d0 = 0; a0 = 0; b0 = 0; g0 = 0;
    v1 = 0; d1 = 0; a1 = 0; b1 = 0; g1 = 0;

    // Reset state
    #1;
    chk("rst.ready", r0, 0);
    chk("rst.ctro", ctro0, 0);
    chk("rst.inflight", infl0, 0);
    chk("rst.busy", busy0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel.ready_before_edge", r0, 0);
    @(negedge clk);
    chk("rel.ready_after_edge", r0, 1);
    chk("rel.poh_pov", {poh0, pov0}, 0);

    // T1: reset in the middle of RUN
    send(0, 16'hF0F0, 16'h1234, 16'h100B, w);
    send(0, 16'h0F0F, 16'h5678, 16'h100B, w);
    chk("t1.load_bo", bo0, 16'h1234);
    chk("t1.load_ctro", ctro0, 0);
    repeat (5) @(negedge clk);
    chk("t1.k5_ctro", ctro0, 1);
    chk("t1.k5_inflight", infl0, 1);
    #2 rst = 1'b0;
    #1;
    chk("t1.rst_ctro", ctro0, 0);
    chk("t1.rst_buses", {ao0, go0, bo0, po0}, 0);
    chk("t1.rst_inflight", infl0, 0);
    chk("t1.rst_ready", r0, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1.after_busy", busy0, 0);
    chk("t1.after_ctro", ctro0, 0);
    chk("t1.after_bo", bo0, 0);
    chk("t1.after_ready", r0, 1);

    // T2: single operation as a table, plus done_i retire and done_i at zero
    tv.push_back(mk(1, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 1));
    tv.push_back(mk(0, 0, 1, 0, 0, TA, TB, TG, 4'd1, 1));
    for (int k = 1; k <= 16; k++)
      tv.push_back(mk(0, 0, 1, 1, (k == 1 || k == 16), TA, TB, TG, 4'd1, 1));
    tv.push_back(mk(0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 4'd1, 1));
    tv.push_back(mk(0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 4'd1, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 0));
    a0 = TA; b0 = TB; g0 = TG;
    foreach (tv[i]) begin
      v0 = tv[i].vld;
      d0 = tv[i].done;
      @(negedge clk);
      chk($sformatf("t2[%0d].ready", i), r0, tv[i].x_rdy);
      chk($sformatf("t2[%0d].ctro", i), ctro0, tv[i].x_ctro);
      chk($sformatf("t2[%0d].po", i), po0, tv[i].x_po);
      chk($sformatf("t2[%0d].ao", i), ao0, tv[i].x_ao);
      chk($sformatf("t2[%0d].bo", i), bo0, tv[i].x_bo);
      chk($sformatf("t2[%0d].go", i), go0, tv[i].x_go);
      chk($sformatf("t2[%0d].inflight", i), infl0, tv[i].x_infl);
      chk($sformatf("t2[%0d].busy", i), busy0, tv[i].x_busy);
    end
    v0 = 0; d0 = 0;

    // T3: four requests with valid held; fourth stalls on a full FIFO
    fork
      begin
        send(0, 16'h1111, 16'hA001, TG, st[0]);
        send(0, 16'h2222, 16'hA002, TG, st[1]);
        send(0, 16'h3333, 16'hA003, TG, st[2]);
        send(0, 16'h4444, 16'hA004, TG, st[3]);
      end
      log_cycles(0, 80);
    join
    chk("t3.wait_first3", st[0] + st[1] + st[2], 0);
    chk("t3.wait_fourth", st[3], 17);
    l0 = -1;
    for (int i = 0; i < 20; i++)
      if (l0 < 0 && lc[i] == 1'b0 && lb[i] == 16'hA001) l0 = i;
    chk("t3.first_load_idx", l0, 1);
    if (l0 >= 0)
      for (int f = 0; f < 4; f++)
        chk($sformatf("t3.frame%0d", f), frame_ok(l0 + 18 * f, 16'hA001 + 16'(f), 1'b1), 1);
    chk("t3.inflight", infl0, 4);
    chk("t3.busy", busy0, 0);

    // T5: done_i coinciding with LOAD entry
    d0 = 1'b1;
    repeat (3) @(negedge clk);
    d0 = 1'b0;
    chk("t5.drained", infl0, 1);
    send(0, 16'h5555, 16'hB005, TG, w);
    d0 = 1'b1;
    @(negedge clk);
    d0 = 1'b0;
    chk("t5.load_bo", bo0, 16'hB005);
    chk("t5.inflight_same_edge", infl0, 1);
    repeat (18) @(negedge clk);
    d0 = 1'b1;
    @(negedge clk);
    chk("t5.retire", infl0, 0);
    @(negedge clk);
    d0 = 1'b0;
    chk("t5.no_wrap", infl0, 0);

    // T4 + T6: limit of two in flight with no gap between frames
    fork
      begin
        send(1, 16'h0101, 16'hC001, TG, st[0]);
        send(1, 16'h0202, 16'hC002, TG, st[1]);
        send(1, 16'h0303, 16'hC003, TG, st[2]);
      end
      log_cycles(1, 45);
    join
    chk("t4.waits", st[0] + st[1] + st[2], 0);
    chk("t4.frameA", frame_ok(1, 16'hC001, 1'b0), 1);
    chk("t4.frameB", frame_ok(18, 16'hC002, 1'b0), 1);
    chk("t6.seam", {lc[17], lc[18], lc[19]}, 3'b101);
    chk("t4.withheld", {lc[35], lc[44], lb[35], lb[44]}, 0);
    chk("t4.busy", busy1, 1);
    chk("t4.inflight", infl1, 2);
    d1 = 1'b1;
    @(negedge clk);
    d1 = 1'b0;
    chk("t4.after_done_inflight", infl1, 1);
    chk("t4.after_done_idle", {ctro1, bo1}, 0);
    @(negedge clk);
    chk("t4.third_load_bo", bo1, 16'hC003);
    chk("t4.third_load_ctro", ctro1, 0);
    chk("t4.third_inflight", infl1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
